// File: rtl/ccm_pkg.sv
// Shared types, coefficient indices and identity matrix for the colour correction matrix.
package ccm_pkg;

  localparam int CCM_PX_WIDTH    = 10;
  localparam int CCM_FRACT_WIDTH = 10;
  localparam int CCM_INT_WIDTH   = 3;
  localparam int CCM_COEF_WIDTH  = CCM_INT_WIDTH + CCM_FRACT_WIDTH;
  localparam int CCM_ID_WIDTH    = 4;
  localparam int CCM_DEST_WIDTH  = 4;
  localparam int CCM_NUM_COEF    = 9;

  typedef logic signed [CCM_COEF_WIDTH-1:0] coef_t;

  // Row-major indices: output channel row, input channel column (R, G, B).
  localparam int CCM_RR = 0;
  localparam int CCM_RG = 1;
  localparam int CCM_RB = 2;
  localparam int CCM_GR = 3;
  localparam int CCM_GG = 4;
  localparam int CCM_GB = 5;
  localparam int CCM_BR = 6;
  localparam int CCM_BG = 7;
  localparam int CCM_BB = 8;

  localparam coef_t CCM_ONE = coef_t'(1 << CCM_FRACT_WIDTH);

  localparam coef_t CCM_IDENTITY [CCM_NUM_COEF] = '{
    CCM_ONE,   coef_t'(0), coef_t'(0),
    coef_t'(0), CCM_ONE,   coef_t'(0),
    coef_t'(0), coef_t'(0), CCM_ONE
  };

  // True for the diagonal entries of the matrix.
  function automatic logic ccm_is_diag(input int idx);
    return (idx == CCM_RR) || (idx == CCM_GG) || (idx == CCM_BB);
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream pixel bus shared by the video pipeline stages.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4
) ();
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tstrb;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic                   tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/ccm_dot3.sv
// One output channel: 3 products, 3-term sum, then round/clamp into a register.
module ccm_dot3 #(
  parameter int PX_WIDTH    = 10,
  parameter int COEF_WIDTH  = 13,
  parameter int FRACT_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [PX_WIDTH-1:0]          x0_i,
  input  logic [PX_WIDTH-1:0]          x1_i,
  input  logic [PX_WIDTH-1:0]          x2_i,
  input  logic signed [COEF_WIDTH-1:0] k0_i,
  input  logic signed [COEF_WIDTH-1:0] k1_i,
  input  logic signed [COEF_WIDTH-1:0] k2_i,
  output logic [PX_WIDTH-1:0]          y_o
);
  localparam int PW = PX_WIDTH + 1 + COEF_WIDTH;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] HALF   = SW'(64'd1 << (FRACT_WIDTH - 1));
  localparam logic signed [SW-1:0] PX_MAX = SW'((64'd1 << PX_WIDTH) - 64'd1);

  logic signed [PW-1:0] p0_q, p1_q, p2_q;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] shf;
  logic [PX_WIDTH-1:0]  clamp;

  // Stage 1: pixels are unsigned, so zero-extend before the signed multiply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else if (en_i) begin
      p0_q <= PW'($signed({1'b0, x0_i})) * PW'(k0_i);
      p1_q <= PW'($signed({1'b0, x1_i})) * PW'(k1_i);
      p2_q <= PW'($signed({1'b0, x2_i})) * PW'(k2_i);
    end
  end

  // Stage 2: sum with two guard bits so three full-scale products cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
    end
  end

  // Round half up, drop the fraction, then saturate into the pixel range.
  always_comb begin
    rnd   = sum_q + HALF;
    shf   = rnd >>> FRACT_WIDTH;
    clamp = shf[PX_WIDTH-1:0];
    if (shf[SW-1]) begin
      clamp = '0;
    end else if (shf > PX_MAX) begin
      clamp = '1;
    end
  end

  // Stage 3: registered result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_o <= '0;
    end else if (en_i) begin
      y_o <= clamp;
    end
  end

endmodule

// File: rtl/color_correction_matrix.sv
// Programmable signed 3x3 colour correction with frame-aligned coefficient banks.
// Handshake: a beat transfers on a clock edge where tvalid && tready; the
// pipeline advances only when the output slot is free or being drained
// (en = out.tready || !out.tvalid), and in.tready is exactly that enable.
module color_correction_matrix
  import ccm_pkg::*;
#(
  parameter int PX_WIDTH    = CCM_PX_WIDTH,
  parameter int FRACT_WIDTH = CCM_FRACT_WIDTH,
  parameter int INT_WIDTH   = CCM_INT_WIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 coef_wr_i,
  input  logic [3:0]                           coef_addr_i,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] coef_data_i,
  input  logic                                 bypass_i,
  axi4_stream_if.slave                         video_i,
  axi4_stream_if.master                        video_o
);
  localparam int COEF_WIDTH  = INT_WIDTH + FRACT_WIDTH;
  localparam int PIX_BITS    = 3 * PX_WIDTH;
  localparam int TDATA_WIDTH = ((PIX_BITS + 7) / 8) * 8;
  localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;
  localparam int SB_WIDTH    = 2 + 2 * KEEP_WIDTH + CCM_ID_WIDTH + CCM_DEST_WIDTH;
  localparam logic [TDATA_WIDTH-1:0] PIX_MASK = TDATA_WIDTH'((64'd1 << PIX_BITS) - 64'd1);
  localparam logic signed [COEF_WIDTH-1:0] K_ONE = COEF_WIDTH'(64'd1 << FRACT_WIDTH);

  logic signed [COEF_WIDTH-1:0] pend_k [CCM_NUM_COEF];
  logic signed [COEF_WIDTH-1:0] act_k  [CCM_NUM_COEF];
  logic signed [COEF_WIDTH-1:0] k_eff  [CCM_NUM_COEF];
  logic                         pend_byp, act_byp, byp_eff;

  logic en, acc, sof_acc;
  logic [2:0]             vld_q, byp_q;
  logic [TDATA_WIDTH-1:0] pix_q [3];
  logic [SB_WIDTH-1:0]    sb_q  [3];
  logic [SB_WIDTH-1:0]    sb_in;
  logic [PX_WIDTH-1:0]    px_r, px_g, px_b;
  logic [PX_WIDTH-1:0]    y [3];
  logic [TDATA_WIDTH-1:0] out_pix;

  assign en             = video_o.tready || !video_o.tvalid;
  assign video_i.tready = en;
  assign acc            = video_i.tvalid && en;
  assign sof_acc        = acc && video_i.tuser;

  assign px_r  = video_i.tdata[3*PX_WIDTH-1 -: PX_WIDTH];
  assign px_b  = video_i.tdata[2*PX_WIDTH-1 -: PX_WIDTH];
  assign px_g  = video_i.tdata[PX_WIDTH-1 -: PX_WIDTH];
  assign sb_in = {video_i.tlast, video_i.tuser, video_i.tstrb, video_i.tkeep,
                  video_i.tid, video_i.tdest};

  // Pending bank takes writes; active bank reloads from the pre-write pending
  // values on an accepted SOF beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CCM_NUM_COEF; i++) begin
        pend_k[i] <= ccm_is_diag(i) ? K_ONE : '0;
        act_k[i]  <= ccm_is_diag(i) ? K_ONE : '0;
      end
      pend_byp <= 1'b0;
      act_byp  <= 1'b0;
    end else begin
      pend_byp <= bypass_i;
      if (coef_wr_i && (coef_addr_i < 4'(CCM_NUM_COEF))) begin
        pend_k[coef_addr_i] <= coef_data_i;
      end
      if (sof_acc) begin
        for (int i = 0; i < CCM_NUM_COEF; i++) begin
          act_k[i] <= pend_k[i];
        end
        act_byp <= pend_byp;
      end
    end
  end

  // The SOF pixel itself must already see the incoming bank.
  always_comb begin
    for (int i = 0; i < CCM_NUM_COEF; i++) begin
      k_eff[i] = sof_acc ? pend_k[i] : act_k[i];
    end
    byp_eff = sof_acc ? pend_byp : act_byp;
  end

  // Valid, bypass, raw pixel and sideband delay lines matching the 3-stage datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      byp_q <= '0;
      for (int s = 0; s < 3; s++) begin
        pix_q[s] <= '0;
        sb_q[s]  <= '0;
      end
    end else if (en) begin
      vld_q    <= {vld_q[1:0], video_i.tvalid};
      byp_q    <= {byp_q[1:0], byp_eff};
      pix_q[0] <= video_i.tdata;
      pix_q[1] <= pix_q[0];
      pix_q[2] <= pix_q[1];
      sb_q[0]  <= sb_in;
      sb_q[1]  <= sb_q[0];
      sb_q[2]  <= sb_q[1];
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    ccm_dot3 #(
      .PX_WIDTH    (PX_WIDTH),
      .COEF_WIDTH  (COEF_WIDTH),
      .FRACT_WIDTH (FRACT_WIDTH)
    ) u_dot (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (en),
      .x0_i  (px_r),
      .x1_i  (px_g),
      .x2_i  (px_b),
      .k0_i  (k_eff[3*c]),
      .k1_i  (k_eff[3*c+1]),
      .k2_i  (k_eff[3*c+2]),
      .y_o   (y[c])
    );
  end

  // Repack channel results into the R/B/G tdata layout with zero padding.
  always_comb begin
    out_pix = '0;
    out_pix[3*PX_WIDTH-1 -: PX_WIDTH] = y[0];
    out_pix[2*PX_WIDTH-1 -: PX_WIDTH] = y[2];
    out_pix[PX_WIDTH-1 -: PX_WIDTH]   = y[1];
  end

  assign video_o.tvalid = vld_q[2];
  assign video_o.tdata  = byp_q[2] ? (pix_q[2] & PIX_MASK) : out_pix;
  assign {video_o.tlast, video_o.tuser, video_o.tstrb, video_o.tkeep,
          video_o.tid, video_o.tdest} = sb_q[2];

endmodule

// File: tb/tb_color_correction_matrix.sv
// Directed plus randomised-backpressure bench for color_correction_matrix.
module tb_color_correction_matrix;
  import ccm_pkg::*;

  localparam int EW = 50;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        coef_wr_i;
  logic [3:0]  coef_addr_i;
  logic signed [12:0] coef_data_i;
  logic        bypass_i;

  axi4_stream_if vin ();
  axi4_stream_if vout ();

  color_correction_matrix dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .coef_wr_i   (coef_wr_i),
    .coef_addr_i (coef_addr_i),
    .coef_data_i (coef_data_i),
    .bypass_i    (bypass_i),
    .video_i     (vin),
    .video_o     (vout)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  logic        chk_lat = 1'b1;
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_pix = '0;

  coef_t m_pend [CCM_NUM_COEF];
  coef_t m_act  [CCM_NUM_COEF];
  logic  m_pend_byp, m_act_byp;

  logic          stall_seen = 1'b0;
  logic [EW:0]   held = '0;
  logic [EW-1:0] obs, exp_e;
  logic [31:0]   pix;
  logic [9:0]    in_r, in_g, in_b;
  int            acc_c;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [9:0] chan(input coef_t k0, input coef_t k1, input coef_t k2,
                                      input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    longint s;
    s = longint'(k0) * longint'(r) + longint'(k1) * longint'(g) + longint'(k2) * longint'(b);
    s = (s + 512) >>> 10;
    if (s < 0) return 10'd0;
    if (s > 1023) return 10'd1023;
    return 10'(s);
  endfunction

  // Monitor (scoreboard pop, stall stability) then reference model (scoreboard push).
  always @(negedge clk) begin
    obs = {vout.tdata, vout.tuser, vout.tlast, vout.tid, vout.tdest, vout.tkeep, vout.tstrb};
    check("tready_rule", vin.tready, vout.tready || !vout.tvalid);
    if (stall_seen && !rst_i) check("stall_hold", {vout.tvalid, obs}, held);
    stall_seen = vout.tvalid && !vout.tready;
    held = {vout.tvalid, obs};
    if (vout.tvalid && vout.tready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        acc_c = acc_q.pop_front();
        check("pixel", obs, exp_e);
        if (chk_lat) check("latency", 64'(cyc - acc_c), 3);
      end
    end
    if (rst_i) begin
      exp_q.delete();
      acc_q.delete();
      m_pend = CCM_IDENTITY;
      m_act  = CCM_IDENTITY;
      m_pend_byp = 1'b0;
      m_act_byp  = 1'b0;
    end else begin
      if (vin.tvalid && vin.tready) begin
        if (vin.tuser) begin
          m_act = m_pend;
          m_act_byp = m_pend_byp;
        end
        in_r = vin.tdata[29:20];
        in_b = vin.tdata[19:10];
        in_g = vin.tdata[9:0];
        if (ovr_en) pix = ovr_pix;
        else if (m_act_byp) pix = vin.tdata & 32'h3FFF_FFFF;
        else pix = {2'b00,
                    chan(m_act[CCM_RR], m_act[CCM_RG], m_act[CCM_RB], in_r, in_g, in_b),
                    chan(m_act[CCM_BR], m_act[CCM_BG], m_act[CCM_BB], in_r, in_g, in_b),
                    chan(m_act[CCM_GR], m_act[CCM_GG], m_act[CCM_GB], in_r, in_g, in_b)};
        exp_q.push_back({pix, vin.tuser, vin.tlast, vin.tid, vin.tdest, vin.tkeep, vin.tstrb});
        acc_q.push_back(cyc);
      end
      if (coef_wr_i && coef_addr_i < 4'd9) m_pend[coef_addr_i] = coef_data_i;
      m_pend_byp = bypass_i;
    end
  end

  // Driver tasks (all enter and leave at posedge + 1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_wr_i   = 1'b1;
    coef_addr_i = 4'(addr);
    coef_data_i = 13'(val);
    step();
    coef_wr_i = 1'b0;
  endtask

  task automatic write_row0(input int a, input int b, input int c);
    write_coef(0, a);
    write_coef(1, b);
    write_coef(2, c);
  endtask

  task automatic send(input int r, input int g, input int b, input logic sof,
                      input logic ovr, input int er, input int eg, input int eb);
    logic ok;
    vin.tdata  = {2'b00, 10'(r), 10'(b), 10'(g)};
    vin.tuser  = sof;
    vin.tlast  = ($urandom_range(0, 7) == 0);
    vin.tid    = 4'($urandom_range(0, 15));
    vin.tdest  = 4'($urandom_range(0, 15));
    vin.tkeep  = 4'($urandom_range(0, 15));
    vin.tstrb  = 4'($urandom_range(0, 15));
    vin.tvalid = 1'b1;
    ovr_en  = ovr;
    ovr_pix = {2'b00, 10'(er), 10'(eb), 10'(eg)};
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (vin.tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", ok, 1);
    step();
    vin.tvalid = 1'b0;
    ovr_en = 1'b0;
  endtask

  task automatic send_exp(input int r, input int g, input int b, input logic sof,
                          input int er, input int eg, input int eb);
    send(r, g, b, sof, 1'b1, er, eg, eb);
  endtask

  task automatic send_rand(input logic sof);
    send($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
         sof, 1'b0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic done;

  initial begin
    rst_i = 1'b1; coef_wr_i = 1'b0; coef_addr_i = '0; coef_data_i = '0; bypass_i = 1'b0;
    vin.tvalid = 1'b0; vin.tdata = '0; vin.tuser = 1'b0; vin.tlast = 1'b0;
    vin.tid = '0; vin.tdest = '0; vin.tkeep = '0; vin.tstrb = '0;
    vout.tready = 1'b1;
    step();
    @(negedge clk);
    check("reset_tvalid", vout.tvalid, 0);
    check("reset_tdata", vout.tdata, 0);
    check("reset_tuser", vout.tuser, 0);
    check("reset_tready", vin.tready, 1);
    step();
    rst_i = 1'b0;
    step();

    // Identity pass-through, 3-cycle latency
    send_exp(100, 200, 300, 1'b1, 100, 200, 300);
    repeat (5) step();

    // Pending write only takes effect at the next SOF
    write_row0(1536, -512, 0);
    send_exp(400, 200, 0, 1'b0, 400, 200, 0);
    send_exp(400, 200, 0, 1'b1, 500, 200, 0);

    // Saturation both ends
    write_row0(2048, 0, 0);
    send_exp(800, 0, 0, 1'b1, 1023, 0, 0);
    write_row0(0, -1024, 0);
    send_exp(0, 50, 0, 1'b1, 0, 50, 0);

    // Round half up
    write_row0(512, 0, 0);
    send_exp(3, 0, 0, 1'b1, 2, 0, 0);
    send_exp(2, 0, 0, 1'b1, 1, 0, 0);

    // Write coinciding with SOF lands in pending only
    coef_wr_i = 1'b1; coef_addr_i = 4'd0; coef_data_i = 13'sd1024;
    send_exp(10, 0, 0, 1'b1, 5, 0, 0);
    coef_wr_i = 1'b0;
    send_exp(10, 0, 0, 1'b1, 10, 0, 0);

    // Bypass and ignored addresses
    bypass_i = 1'b1;
    write_coef(0, 2048);
    send_exp(100, 7, 9, 1'b0, 100, 7, 9);
    send_exp(800, 1, 2, 1'b1, 800, 1, 2);
    bypass_i = 1'b0;
    write_coef(12, -4096);
    send_exp(800, 0, 0, 1'b1, 1023, 0, 0);
    drain();

    // Random backpressure over 1000 pixels with random matrix changes
    chk_lat = 1'b0;
    for (int i = 0; i < 9; i++) write_coef(i, $urandom_range(0, 8191));
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if (i % 97 == 5) write_coef($urandom_range(0, 15), $urandom_range(0, 8191));
          if (i % 211 == 100) bypass_i = ~bypass_i;
          send_rand(i % 128 == 0);
        end
        done = 1'b1;
      end
      begin
        for (int k = 0; !done; k++) begin
          if ((k >= 20 && k < 25) || (k >= 400 && k < 405)) vout.tready = 1'b0;
          else vout.tready = ($urandom_range(0, 99) < 60);
          step();
        end
        vout.tready = 1'b1;
      end
    join
    bypass_i = 1'b0;
    vout.tready = 1'b1;
    drain();

    // Reset with the pipeline full
    chk_lat = 1'b1;
    send_rand(1'b1);
    send_rand(1'b0);
    send_rand(1'b0);
    send_rand(1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_tready", vin.tready, 1);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", vout.tvalid, 0);
    check("midrst_tdata", vout.tdata, 0);
    step();
    send_exp(100, 200, 300, 1'b1, 100, 200, 300);
    send_exp(300, 20, 1023, 1'b0, 300, 20, 1023);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
